// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) game core.
package genius_pkg;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        APPEND   = 3'd1,
        SHOW_ON  = 3'd2,
        SHOW_GAP = 3'd3,
        WAIT_IN  = 3'd4,
        OVER     = 3'd5,
        DONE     = 3'd6
    } state_e;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] onehot4(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 16-bit Galois LFSR; the low two bits supply the next colour.
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic   clk,
    input  logic   rst_n,
    output color_t color
);

    logic [15:0] lfsr;

    // Shift right every cycle, folding the taps in whenever a 1 drops out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
        end
    end

    assign color = lfsr[1:0];

endmodule

// File: rtl/sequence_checker.sv
// Genius game core: grows a random sequence, plays it back, checks player presses.
module sequence_checker
    import genius_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned SHOW_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    output logic [3:0] led,
    output logic       input_ready,
    output logic       level_up,
    output logic       game_over,
    output logic       win
);

    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMR_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(SHOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN);

    state_e           state;
    logic [LEN_W-1:0] len;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [TMR_W-1:0] timer;
    color_t           new_color;
    color_t           cur_color;
    color_t           mem [MAX_LEN];

    genius_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .color (new_color)
    );

    assign cur_color   = mem[idx];
    assign last_idx    = IDX_W'(len - 1'b1);
    assign led         = (state == SHOW_ON) ? onehot4(cur_color) : '0;
    assign input_ready = (state == WAIT_IN);

    // Sequence memory: one new colour appended per round, never reset.
    always_ff @(posedge clk) begin
        if (state == APPEND) begin
            mem[IDX_W'(len)] <= new_color;
        end
    end

    // Game FSM with playback timer, position index, length and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len       <= '0;
            idx       <= '0;
            timer     <= '0;
            level_up  <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            level_up <= 1'b0;
            case (state)
                IDLE, OVER, DONE: begin
                    if (start) begin
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        len       <= '0;
                        state     <= APPEND;
                    end
                end
                APPEND: begin
                    len   <= len + 1'b1;
                    idx   <= '0;
                    timer <= '0;
                    state <= SHOW_ON;
                end
                SHOW_ON: begin
                    if (timer == SHOW_LAST) begin
                        timer <= '0;
                        state <= SHOW_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SHOW_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (idx == last_idx) begin
                            idx   <= '0;
                            state <= WAIT_IN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SHOW_ON;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (btn_valid) begin
                        if (btn_color != cur_color) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else if (idx != last_idx) begin
                            idx <= idx + 1'b1;
                        end else begin
                            level_up <= 1'b1;
                            if (len == LEN_FULL) begin
                                win   <= 1'b1;
                                state <= DONE;
                            end else begin
                                state <= APPEND;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: default instance plus a MAX_LEN=2 instance.
module tb_sequence_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, bv1, start2, bv2;
    logic [1:0] bc1, bc2;
    logic [3:0] led1, led2;
    logic       ir1, lu1, go1, win1;
    logic       ir2, lu2, go2, win2;

    int passed = 0;
    int total  = 0;

    logic [15:0] model;
    logic [1:0]  cols [0:31];

    always #5 clk = ~clk;

    sequence_checker #(
        .MAX_LEN     (32),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (2),
        .LFSR_SEED   (16'hACE1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start1),
        .btn_valid   (bv1),
        .btn_color   (bc1),
        .led         (led1),
        .input_ready (ir1),
        .level_up    (lu1),
        .game_over   (go1),
        .win         (win1)
    );

    sequence_checker #(
        .MAX_LEN     (2),
        .SHOW_CYCLES (4),
        .GAP_CYCLES  (2),
        .LFSR_SEED   (16'hACE1)
    ) u_dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start2),
        .btn_valid   (bv2),
        .btn_color   (bc2),
        .led         (led2),
        .input_ready (ir2),
        .level_up    (lu2),
        .game_over   (go2),
        .win         (win2)
    );

    // Reference Galois LFSR (x^16+x^14+x^13+x^11), stepping every cycle like the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model <= 16'hACE1;
        else        model <= {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [3:0] oh(input logic [1:0] c);
        oh = 4'b0001 << c;
    endfunction

    function automatic logic [7:0] outs(input int sel);
        if (sel == 0) outs = {led1, ir1, lu1, go1, win1};
        else          outs = {led2, ir2, lu2, go2, win2};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_outs(input int sel, input string tag, input logic [3:0] el,
                            input logic ei, input logic elu, input logic ego, input logic ewin);
        chk(tag, {24'b0, outs(sel)}, {24'b0, el, ei, elu, ego, ewin});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic v, input logic [1:0] c);
        if (sel == 0) begin start1 = s; bv1 = v; bc1 = c; end
        else          begin start2 = s; bv2 = v; bc2 = c; end
    endtask

    // Called in the first SHOW_ON cycle; checks every playback cycle, returns in WAIT_IN.
    // pk: 0 none, 1 start pulse, 2 wrong-colour button pulse, applied at cycles p1/p2.
    task automatic play_round(input int sel, input int n, input int pk, input int p1, input int p2);
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 6; k++) begin
                chk_outs(sel, $sformatf("r%0d_play_c%0d", n, cyc),
                         (k < 4) ? oh(cols[i]) : 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
                if (pk != 0 && (cyc == p1 || cyc == p2))
                    drive(sel, pk == 1, pk == 2, cols[i] + 2'd1);
                else
                    drive(sel, 1'b0, 1'b0, 2'd0);
                tick();
                cyc++;
            end
        end
        drive(sel, 1'b0, 1'b0, 2'd0);
        chk_outs(sel, $sformatf("r%0d_wait", n), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Presses the whole sequence correctly; ends in the cycle after the last press.
    task automatic press_seq(input int sel, input int n, input logic ewin);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b0, 1'b1, cols[i]);
            tick();
            drive(sel, 1'b0, 1'b0, 2'd0);
            if (i < n - 1)
                chk_outs(sel, $sformatf("r%0d_press%0d", n, i), 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
            else
                chk_outs(sel, $sformatf("r%0d_lvlup", n), 4'b0000, 1'b0, 1'b1, 1'b0, ewin);
        end
        if (!ewin) cols[n] = model[1:0];
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 2'd0);
        drive(1, 1'b0, 1'b0, 2'd0);
        tick(); tick(); tick();
        chk_outs(0, "reset_state", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_outs(1, "reset_state2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); tick();
        chk_outs(0, "idle_after_release", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Round 1 and 2 with plain correct play.
        drive(0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        chk_outs(0, "append1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cols[0] = model[1:0];
        tick();
        play_round(0, 1, 0, 0, 0);
        press_seq(0, 1, 1'b0);
        tick();
        chk_outs(0, "single_pulse", oh(cols[0]), 1'b0, 1'b0, 1'b0, 1'b0);
        play_round(0, 2, 0, 0, 0);
        press_seq(0, 2, 1'b0);
        tick();

        // Round 3: start during SHOW_ON, SHOW_GAP and WAIT_IN is ignored.
        play_round(0, 3, 1, 1, 10);
        drive(0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        chk_outs(0, "start_in_wait", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        press_seq(0, 3, 1'b0);
        tick();

        // Round 4: wrong-colour presses during playback (incl. last gap cycle) dropped.
        play_round(0, 4, 2, 2, 23);
        press_seq(0, 4, 1'b0);
        tick();

        // Round 5: wrong second press ends the game.
        play_round(0, 5, 0, 0, 0);
        drive(0, 1'b0, 1'b1, cols[0]);
        tick();
        chk_outs(0, "r5_first_ok", 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, cols[1] + 2'd1);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        chk_outs(0, "r5_wrong", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 1'b1, cols[i]);
            tick();
            chk_outs(0, "over_hold", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // New game from OVER; round 1 wrong press.
        drive(0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        chk_outs(0, "restart_clears", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cols[0] = model[1:0];
        tick();
        play_round(0, 1, 0, 0, 0);
        drive(0, 1'b0, 1'b1, cols[0] + 2'd1);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        chk_outs(0, "r1_wrong", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_outs(0, "r1_wrong_hold", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-SHOW_ON.
        drive(0, 1'b1, 1'b0, 2'd0);
        tick();
        drive(0, 1'b0, 1'b0, 2'd0);
        cols[0] = model[1:0];
        tick(); tick(); tick();
        chk_outs(0, "pre_reset_show", oh(cols[0]), 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_outs(0, "reset_mid_show", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b1, cols[0]);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs(0, "stays_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(0, 1'b0, 1'b0, 2'd0);

        // MAX_LEN=2 instance: two rounds then win, no third round.
        drive(1, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0);
        chk_outs(1, "m2_append1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cols[0] = model[1:0];
        tick();
        play_round(1, 1, 0, 0, 0);
        press_seq(1, 1, 1'b0);
        tick();
        play_round(1, 2, 0, 0, 0);
        press_seq(1, 2, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_outs(1, "m2_done_hold", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        drive(1, 1'b1, 1'b0, 2'd0);
        tick();
        drive(1, 1'b0, 1'b0, 2'd0);
        chk_outs(1, "m2_restart_clears", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
